// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache controller.
// Fetch looks up combinationally: a hit answers in the same cycle. A miss stalls
// fetch, refills the whole line from memory in one beat, then replays the lookup.
// Optional build macro ICACHE_STATS_EN adds 32-bit hit_count / miss_count outputs.
// LINE_WORDS and NUM_LINES must be powers of two, each at least 2.
module icache_controller #(
  parameter int ARCH_LEN   = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [ARCH_LEN-1:0]        req_addr,
  input  logic                       flush,
  output logic                       rsp_valid,
  output logic [31:0]                rsp_data,
  output logic                       stall_out,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ARCH_LEN-1:0]        mem_req_addr,
  input  logic                       mem_rsp_valid,
  input  logic [32*LINE_WORDS-1:0]   mem_rsp_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
`endif
);

  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = 2 + WSEL_W;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ARCH_LEN - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, FILL} state_t;

  state_t                       state_q;
  logic [NUM_LINES-1:0]         valid_q;
  logic [TAG_W-1:0]             tag_q  [NUM_LINES];
  logic [32*LINE_WORDS-1:0]     data_q [NUM_LINES];
  logic [ARCH_LEN-OFF_W-1:0]    miss_line_q;   // tag+index of the line being refilled
  logic [32*LINE_WORDS-1:0]     line_q;        // refill beat, written into the arrays in FILL
  logic                         flush_pend_q;
  logic                         mem_req_valid_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_word;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              lookup_hit;
  logic              unused_addr_lsbs;

  assign req_idx    = req_addr[OFF_W +: IDX_W];
  assign req_tag    = req_addr[ARCH_LEN-1 -: TAG_W];
  assign req_word   = req_addr[2 +: WSEL_W];
  assign fill_idx   = miss_line_q[0 +: IDX_W];
  assign fill_tag   = miss_line_q[ARCH_LEN-OFF_W-1 -: TAG_W];
  assign lookup_hit = req_valid && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Byte offset within the word is irrelevant for 32-bit instruction fetch.
  assign unused_addr_lsbs = ^req_addr[1:0];

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = {miss_line_q, {OFF_W{1'b0}}};

  // Fetch-side response: same-cycle hit data, stall on miss/flush or while refilling.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_data  = 32'd0;
    stall_out = 1'b1;
    if (state_q == IDLE) begin
      stall_out = flush || (req_valid && !lookup_hit);
      if (lookup_hit && !flush) begin
        rsp_valid = 1'b1;
        rsp_data  = data_q[req_idx][32*req_word +: 32];
      end
    end
  end

  // Refill controller: miss detect, request handshake, response wait, fill; owns valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      flush_pend_q    <= 1'b0;
      mem_req_valid_q <= 1'b0;
      miss_line_q     <= '0;
      line_q          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A flush takes priority over starting a refill; the replay next cycle will miss.
          if (flush) begin
            valid_q <= '0;
          end else if (req_valid && !lookup_hit) begin
            miss_line_q     <= req_addr[ARCH_LEN-1:OFF_W];
            mem_req_valid_q <= 1'b1;
            state_q         <= MREQ;
          end
        end
        MREQ: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= MWAIT;
          end
        end
        MWAIT: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_rsp_valid) begin
            line_q  <= mem_rsp_data;
            state_q <= FILL;
          end
        end
        FILL: begin
          // A flush seen anywhere during the refill leaves the new line invalid too.
          if (flush_pend_q || flush) valid_q <= '0;
          else                       valid_q[fill_idx] <= 1'b1;
          flush_pend_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data storage are not reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (!rst && state_q == FILL) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= line_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Event counters: hit cycles and refill starts; free-running, wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (rsp_valid) hit_count_q <= hit_count_q + 32'd1;
      if (state_q == IDLE && !flush && req_valid && !lookup_hit)
        miss_count_q <= miss_count_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Scoreboard bench for icache_controller: directed test-plan cases followed by
// random fetch traffic against a line-level model of a direct-mapped cache.
module tb_icache_controller;

  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic          flush;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          stall_out;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic          mem_rsp_valid;
  logic [32*LW-1:0] mem_rsp_data;
`ifdef ICACHE_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  icache_controller #(.ARCH_LEN(32), .LINE_WORDS(LW), .NUM_LINES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .flush         (flush),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .stall_out     (stall_out),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    int          nmiss;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // memory configuration for the transaction in flight
  int          cfg_wait = 0;
  int          cfg_lat  = 2;
  logic [31:0] exp_line = 32'd0;

  // reference model: one valid bit and one tag per line
  logic        model_valid [16];
  logic [23:0] model_tag   [16];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] line, input int w);
    return (line * 32'h9E37_79B1) ^ (32'(w) << 28) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [32*LW-1:0] mem_line(input logic [31:0] line);
    logic [32*LW-1:0] l;
    for (int w = 0; w < LW; w++) l[32*w +: 32] = mem_word(line, w);
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
  endtask

  // Memory responder: ready after cfg_wait cycles, one-beat response cfg_lat-1 cycles after the handshake.
  initial begin
    int   wait_cnt  = 0;
    int   rsp_timer = -1;
    logic prev_pend = 1'b0;
    logic [31:0] pend_line = 32'd0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      if (rsp_timer == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_line(pend_line);
        rsp_timer     = -1;
      end else if (rsp_timer > 0) begin
        rsp_timer--;
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        if (wait_cnt >= cfg_wait) mem_req_ready = 1'b1;
        else wait_cnt++;
      end
      @(negedge clk);
      if (rst) begin
        wait_cnt  = 0;
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) chk("mem_req_valid_held", {31'd0, mem_req_valid}, 32'd1);
        if (mem_req_valid) chk("mem_req_addr", mem_req_addr, exp_line);
        prev_pend = mem_req_valid && !mem_req_ready;
        if (mem_req_valid && mem_req_ready) begin
          pend_line = mem_req_addr;
          rsp_timer = cfg_lat - 2;
          wait_cnt  = 0;
        end
      end
    end
  end

  // Monitor: pops one expectation per response and checks data, stall cycles and refill count.
  int mon_stall = 0;
  int mon_hs    = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_stall = 0;
        mon_hs    = 0;
      end else begin
        if (stall_out) mon_stall++;
        if (mem_req_valid && mem_req_ready) mon_hs++;
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got data 0x%08h for addr 0x%08h, expected no response", rsp_data, req_addr);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("stall_cycles", 32'(mon_stall), 32'(e.stall));
            chk("refill_count", 32'(mon_hs), 32'(e.nmiss));
          end
          mon_stall = 0;
          mon_hs    = 0;
        end
      end
    end
  end

  // Issue one fetch and hold it until the hit response. flush_at: -1 none,
  // 0 flush in the first (IDLE) cycle, >0 flush that many cycles in (during the refill).
  task automatic issue(input logic [31:0] addr, input int w, input int lat, input int flush_at);
    exp_t e;
    int   idx  = int'(addr[7:4]);
    int   word = int'(addr[3:2]);
    int   cost = 2 + w + lat;
    logic hit  = model_valid[idx] && (model_tag[idx] == addr[31:8]);
    bit   done = 0;
    if (flush_at == 0) begin
      model_clear();
      e.nmiss = 1;
      e.stall = 1 + cost;
    end else if (flush_at > 0) begin
      model_clear();
      e.nmiss = 2;
      e.stall = 2 * cost;
    end else begin
      e.nmiss = hit ? 0 : 1;
      e.stall = e.nmiss * cost;
    end
    model_valid[idx] = 1'b1;
    model_tag[idx]   = addr[31:8];
    e.addr = addr;
    e.data = mem_word({addr[31:4], 4'h0}, word);
    exp_q.push_back(e);
    exp_hits++;
    exp_misses += e.nmiss;
    cfg_wait  = w;
    cfg_lat   = lat;
    exp_line  = {addr[31:4], 4'h0};
    req_valid = 1'b1;
    req_addr  = addr;
    for (int c = 0; c < 100 && !done; c++) begin
      flush = (c == flush_at);
      @(negedge clk);
      if (rsp_valid) done = 1;
      @(posedge clk); #1;
    end
    flush = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: no response for addr 0x%08h within 100 cycles, expected a hit", addr);
      exp_q.delete();
      req_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [23:0] tg;
    int          t;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    flush     = 1'b0;
    model_clear();
    for (int i = 0; i < 16; i++) model_tag[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_stall_out", {31'd0, stall_out}, 32'd0);
    chk("reset_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("reset_mem_req_addr", mem_req_addr, 32'd0);
    @(posedge clk); #1;

    // cold miss (5 stall cycles), same-line hits, conflict eviction, backpressure
    issue(32'h0000_0040, 0, 3, -1);
    issue(32'h0000_0044, 0, 3, -1);
    issue(32'h0000_0048, 0, 3, -1);
    issue(32'h0000_004C, 0, 3, -1);
    issue(32'h0000_0140, 0, 3, -1);
    issue(32'h0000_0040, 1, 2, -1);
    issue(32'h0000_02C4, 4, 3, -1);
    idle(1);

    // flush during the refill of 0x080: replay misses again; 0x040 is gone too
    issue(32'h0000_0080, 0, 4, 2);
    issue(32'h0000_0040, 0, 2, -1);
    // flush in IDLE on a cached line: no response that cycle, then a miss
    issue(32'h0000_0044, 1, 2, 0);
    idle(2);

    // reset during MWAIT followed by a stray memory response
    cfg_wait  = 0;
    cfg_lat   = 6;
    exp_line  = 32'h0000_0300;
    req_addr  = 32'h0000_0304;
    req_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    req_valid = 1'b0;
    model_clear();
    exp_hits   = 0;
    exp_misses = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_stall_out", {31'd0, stall_out}, 32'd0);
    chk("rstmid_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rstmid_mem_req_addr", mem_req_addr, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rstmid_miss_count", miss_count, 32'd0);
`endif
    @(posedge clk); #1;
    idle(6);
    issue(32'h0000_0304, 1, 2, -1);
    issue(32'h0000_0300, 0, 2, -1);

    // random traffic over a small tag set so hits, conflicts and the last index all occur
    for (int n = 0; n < 200; n++) begin
      t  = int'($urandom_range(0, 3));
      tg = (t == 3) ? 24'h80_0001 : 24'(t);
      a  = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      issue(a, int'($urandom_range(0, 3)), int'($urandom_range(2, 5)), -1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, 32'(exp_hits));
    chk("miss_count", miss_count, 32'(exp_misses));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // absolute time bound in case a wait is never satisfied
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
- Direct-mapped, read-only instruction cache controller between fetch_stage (requester) and main_memory (line responder).
- Responds to fetch with a 32-bit instruction word on a hit.
- On a miss it asserts a backward stall, runs a line-refill handshake with memory, fills the line, then replays the lookup.
- Supplies the fetch-side stall source (icache miss) that ORs into stall_fet.

Parameters:
- ARCH_LEN, 32, address width.
- LINE_WORDS, 4, 32-bit words per line; power of 2.
- NUM_LINES, 16, lines in the cache; power of 2.
- Derived: OFF_W = 2 + log2(LINE_WORDS); IDX_W = log2(NUM_LINES); TAG_W = ARCH_LEN - OFF_W - IDX_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  fetch presents an address this cycle
- req_addr  in  ARCH_LEN  fetch PC; bits [1:0] ignored
- flush  in  1  invalidate all lines (fence.i)
- rsp_valid  out  1  rsp_data valid for the current req_addr (hit)
- rsp_data  out  32  instruction word
- stall_out  out  1  miss in progress; fetch must hold the PC
- mem_req_valid  out  1  line refill request
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  ARCH_LEN  line-aligned address (low OFF_W bits zero)
- mem_rsp_valid  in  1  refill data valid, single beat
- mem_rsp_data  in  32*LINE_WORDS  full line; word 0 in the LSBs

Behaviour:
- Storage: per line, valid bit, tag (TAG_W) and data (32*LINE_WORDS). Address fields: idx = req_addr[OFF_W +: IDX_W]; word = req_addr[2 +: log2(LINE_WORDS)].
- Reset (one rst cycle):
  - state = IDLE; all valid bits = 0; flush_pend = 0.
  - rsp_valid = 0, stall_out = 0, mem_req_valid = 0, mem_req_addr = 0, rsp_data = 0.
  - Tag and data arrays are not reset.
- FSM states: IDLE, MREQ, MWAIT, FILL.
- IDLE:
  - Lookup is combinational. hit = req_valid & valid[idx] & tag match.
  - On hit: rsp_valid = 1 and rsp_data = selected word in the same cycle (0-cycle hit latency). stall_out = 0.
  - req_valid & !hit: rsp_valid = 0, stall_out = 1, miss_addr latched, next state MREQ.
  - req_valid = 0: outputs idle, rsp_data = 0.
- MREQ:
  - mem_req_valid = 1, mem_req_addr = line-aligned miss_addr; both held stable until mem_req_ready.
  - On mem_req_ready -> MWAIT.
- MWAIT:
  - mem_req_valid = 0.
  - On mem_rsp_valid: capture the line -> FILL. A mem_rsp_valid in any other state is ignored.
- FILL:
  - Write data and tag to idx(miss_addr); set valid unless flush_pend.
  - Next state IDLE, where the lookup is replayed.
- stall_out = 1 in MREQ, MWAIT and FILL, and in the IDLE miss cycle. rsp_valid = 0 in all non-IDLE states.
- Miss penalty: 1 (detect) + handshake wait + memory latency + 1 (FILL); the hit appears on the first IDLE cycle afterwards.
- Address change during a miss (branch kill): the refill always completes, because a memory transaction is never aborted. The IDLE replay uses the current req_addr and may miss again.
- Flush in IDLE:
  - All valid bits clear at the next edge.
  - rsp_valid is forced to 0 in the flush cycle; stall_out = 1 in that cycle.
- Flush in MREQ/MWAIT/FILL:
  - Sets flush_pend.
  - The FILL still writes data but leaves valid = 0, and all valids clear at that edge; flush_pend clears.
- Flush coincident with rst: rst wins.
- rst mid-miss: return to IDLE immediately; mem_req_valid drops; a later mem_rsp_valid is ignored.
- Index wrap: the last line (idx = NUM_LINES-1) behaves like any other; tags compare on full TAG_W.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count and miss_count, each 32 bits.
  - hit_count increments on each IDLE hit cycle. miss_count increments on each IDLE->MREQ transition.
  - Both counters wrap at 2^32, reset to 0 on rst, and are unaffected by flush.
- When undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Cold miss: after reset, req_addr = 0x0000_0040, memory ready immediately, 3-cycle data latency.
  - Expect: stall_out = 1 for 5 cycles; mem_req_addr = 0x40; then rsp_valid = 1 with rsp_data = word 0 of the line.
- Same-line hits: after the cold miss, req_addr = 0x44, 0x48, 0x4C on consecutive cycles.
  - Expect: rsp_valid = 1 every cycle, the correct words, no mem_req_valid.
- Conflict eviction: fill 0x040, then access 0x140 (same idx, different tag), then 0x040 again.
  - Expect: two further misses, each with the correct mem_req_addr.
- Backpressure: hold mem_req_ready = 0 for 4 cycles.
  - Expect: mem_req_valid and mem_req_addr stable throughout, stall_out = 1.
- Flush: flush while in MWAIT for 0x080.
  - Expect: the fill completes and stall_out drops, but the next lookup of 0x080 misses again; previously cached 0x040 also misses.
- Reset mid-miss: rst during MWAIT, then a stray mem_rsp_valid.
  - Expect: state IDLE, no line written, access to the same address misses.
  - With ICACHE_STATS_EN: miss_count = 0 after reset.
